// File: rtl/binary_to_bcd_converter_pkg.sv
// Shared constants and FSM encoding for the binary-to-BCD converter.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package binary_to_bcd_converter_pkg;

  localparam int         BIN_WIDTH_DEF = 14;
  localparam int         DIGITS        = 4;
  localparam int         MAX_VALUE     = 10**DIGITS - 1;
  localparam logic [3:0] NINE          = 4'd9;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/binary_to_bcd_converter_if.sv
// Request/result bundle between the converter and its client (display stage).
// Latency: none (wires only).
// Backpressure: start is ignored while busy; there is no queuing.
interface binary_to_bcd_converter_if
  import binary_to_bcd_converter_pkg::*;
#(
  parameter int BIN_WIDTH = BIN_WIDTH_DEF
);
  logic                 start;
  logic [BIN_WIDTH-1:0] bin;
  logic                 busy;
  logic                 done;
  logic                 overflow;
  logic [3:0]           v3;
  logic [3:0]           v2;
  logic [3:0]           v1;
  logic [3:0]           v0;

  modport master (
    output start, bin,
    input  busy, done, overflow, v3, v2, v1, v0
  );

  modport slave (
    input  start, bin,
    output busy, done, overflow, v3, v2, v1, v0
  );

endinterface

// File: rtl/binary_to_bcd_converter_add3.sv
// Double-dabble nibble corrector: adds 3 to a BCD digit of 5 or more.
// Latency: combinational.
// Backpressure: none.
module binary_to_bcd_converter_add3 (
  input  logic [3:0] din,
  output logic [3:0] dout
);

  // Digits 0..9 only reach here, so the 4-bit sum never wraps.
  always_comb begin
    dout = (din >= 4'd5) ? din + 4'd3 : din;
  end

endmodule

// File: rtl/binary_to_bcd_converter.sv
// Sequential shift/add-3 converter from unsigned binary to four BCD digits, saturating at 9999.
// Latency: BIN_WIDTH shift cycles after the accepting edge, then a one-cycle done pulse.
// Backpressure: start is accepted only in IDLE or DONE; requests while busy are dropped.
module binary_to_bcd_converter
  import binary_to_bcd_converter_pkg::*;
#(
  parameter int BIN_WIDTH = BIN_WIDTH_DEF
) (
  input logic                       clk_100MHz,
  input logic                       reset,
  binary_to_bcd_converter_if.slave  bus
);

  localparam int          BCD_W   = DIGITS * 4;
  localparam int          SW      = BCD_W + BIN_WIDTH;
  localparam int          CW      = $clog2(BIN_WIDTH + 1);
  localparam logic [31:0] MAX_VAL = 32'(MAX_VALUE);

  state_t            state;
  logic [SW-1:0]     shreg;
  logic [CW-1:0]     cnt;
  logic              ovf;
  logic [BCD_W-1:0]  bcd_q;
  logic              ovf_q;

  logic [BCD_W-1:0]  bcd_corr;
  logic [SW-1:0]     shreg_nxt;
  logic              bin_ovf;

  // One corrector per BCD digit of the shift register.
  for (genvar g = 0; g < DIGITS; g++) begin : g_add3
    binary_to_bcd_converter_add3 u_add3 (
      .din  (shreg[BIN_WIDTH + 4*g +: 4]),
      .dout (bcd_corr[4*g +: 4])
    );
  end

  assign shreg_nxt = {bcd_corr, shreg[BIN_WIDTH-1:0]} << 1;
  assign bin_ovf   = 32'(bus.bin) > MAX_VAL;

  // FSM, iteration counter, shift register and held result registers.
  // The result is captured on the edge that enters DONE so it is already valid while done is high.
  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      shreg <= '0;
      cnt   <= '0;
      ovf   <= 1'b0;
      bcd_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (bus.start) begin
            shreg <= {{BCD_W{1'b0}}, bus.bin};
            cnt   <= '0;
            ovf   <= bin_ovf;
            state <= SHIFT;
          end else begin
            state <= IDLE;
          end
        end
        SHIFT: begin
          shreg <= shreg_nxt;
          cnt   <= cnt + 1'b1;
          if (cnt == CW'(BIN_WIDTH - 1)) begin
            state <= DONE;
            bcd_q <= ovf ? {DIGITS{NINE}} : shreg_nxt[SW-1 -: BCD_W];
            ovf_q <= ovf;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy     = (state == SHIFT);
  assign bus.done     = (state == DONE);
  assign bus.overflow = ovf_q;
  assign bus.v3       = bcd_q[15:12];
  assign bus.v2       = bcd_q[11:8];
  assign bus.v1       = bcd_q[7:4];
  assign bus.v0       = bcd_q[3:0];

endmodule
